// File: rtl/tqvp_wdm_pkg.sv
// Shared register map, bit positions and write-size encoding for the multi-channel watchdog.
package tqvp_wdm_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_OPEN   = 3'd1;
  localparam logic [2:0] OFF_CLOSE  = 3'd2;
  localparam logic [2:0] OFF_PAT    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_COUNT  = 3'd5;

  localparam logic [5:0] ADDR_PRESCALE = 6'h3C;
  localparam logic [5:0] ADDR_IRQ      = 6'h3D;
  localparam logic [5:0] ADDR_UI       = 6'h3E;

  localparam int unsigned CTRL_EN           = 0;
  localparam int unsigned CTRL_EARLY_CHK    = 1;
  localparam int unsigned CTRL_IRQ_EN_EXP   = 2;
  localparam int unsigned CTRL_IRQ_EN_FAULT = 3;

  localparam int unsigned ST_SAW_PAT = 0;
  localparam int unsigned ST_EXPIRED = 1;
  localparam int unsigned ST_EARLY   = 2;
  localparam int unsigned ST_BAD_KEY = 3;

  localparam logic [31:0] PAT_KEY_DEFAULT = 32'hA5C3_5A3C;

  typedef enum logic [1:0] {
    WR_BYTE = 2'b00,
    WR_HALF = 2'b01,
    WR_WORD = 2'b10,
    WR_NONE = 2'b11
  } wr_size_e;

endpackage

// File: rtl/tqvp_wdm_channel.sv
// One watchdog channel: control/window registers, timer, pat evaluation and sticky W1C status.
module tqvp_wdm_channel #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_open_i,
  input  logic             wr_close_i,
  input  logic             wr_pat_i,
  input  logic             wr_status_i,
  input  logic             key_ok_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [3:0]       ctrl_o,
  output logic [CNT_W-1:0] open_o,
  output logic [CNT_W-1:0] close_o,
  output logic [3:0]       status_o,
  output logic [CNT_W-1:0] count_o,
  output logic             irq_o
);
  import tqvp_wdm_pkg::*;

  logic [3:0]       ctrl_q, ctrl_d, status_q, status_d, set_ev;
  logic [CNT_W-1:0] open_q, open_d, close_q, close_d, timer_q, timer_d;
  logic             en, expired, below_open, past_close, pat_hit;

  assign en         = ctrl_q[CTRL_EN];
  assign expired    = status_q[ST_EXPIRED];
  assign below_open = timer_q < open_q;
  assign past_close = timer_q > close_q;

  always_comb begin
    ctrl_d  = wr_ctrl_i ? wdata_i[3:0] : ctrl_q;
    open_d  = (wr_open_i && !en) ? wdata_i : open_q;
    close_d = (wr_close_i && !en) ? wdata_i : close_q;
    set_ev  = '0;
    pat_hit = 1'b0;
    if (wr_pat_i && en) begin
      if (!key_ok_i)                 set_ev[ST_BAD_KEY] = 1'b1;
      else if (below_open)           set_ev[ST_EARLY]   = ctrl_q[CTRL_EARLY_CHK];
      else if (!past_close && !expired) begin
        set_ev[ST_SAW_PAT] = 1'b1;
        pat_hit            = 1'b1;
      end
    end
    if (en && past_close) set_ev[ST_EXPIRED] = 1'b1;
    // The timer holds once it passes CLOSE, so it reads CLOSE+1 while expiry is pending or set.
    timer_d = timer_q;
    if (!en || pat_hit)
      timer_d = '0;
    else if (tick_i && !expired && !past_close && (timer_q != '1))
      timer_d = timer_q + 1'b1;
    status_d = (status_q & ~(wr_status_i ? wdata_i[3:0] : 4'h0)) | set_ev;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      open_q   <= '0;
      close_q  <= '0;
      timer_q  <= '0;
      status_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      open_q   <= open_d;
      close_q  <= close_d;
      timer_q  <= timer_d;
      status_q <= status_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign open_o   = open_q;
  assign close_o  = close_q;
  assign status_o = status_q;
  assign count_o  = timer_q;
  assign irq_o    = (status_q[ST_EXPIRED] & ctrl_q[CTRL_IRQ_EN_EXP]) |
                    ((status_q[ST_EARLY] | status_q[ST_BAD_KEY]) & ctrl_q[CTRL_IRQ_EN_FAULT]);

endmodule

// File: rtl/tqvp_stevej_watchdog_multi.sv
// Multi-channel windowed watchdog: shared prescaler, address decode, read mux and interrupt combine.
module tqvp_stevej_watchdog_multi
  import tqvp_wdm_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned PRE_W   = 8,
  parameter logic [31:0] PAT_KEY = PAT_KEY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  wr_size_e          wr_size;
  logic              wr_en, key_ok, tick, wr_prescale, irq_q, irq_d;
  logic [31:0]       wdata;
  logic [2:0]        ch_sel, off_sel;
  logic [PRE_W-1:0]  prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [7:0][31:0]  rd_all;
  logic [3:0]        exp_vec, irq_vec;
  logic              unused_ok;

  assign wr_size = wr_size_e'(data_write_n);
  assign wr_en   = wr_size != WR_NONE;
  assign key_ok  = (wr_size == WR_WORD) && (data_in == PAT_KEY);
  assign ch_sel  = address[5:3];
  assign off_sel = address[2:0];

  always_comb begin
    case (wr_size)
      WR_BYTE: wdata = {24'h0, data_in[7:0]};
      WR_HALF: wdata = {16'h0, data_in[15:0]};
      default: wdata = data_in;
    endcase
  end

  assign wr_prescale = wr_en && (address == ADDR_PRESCALE);
  assign tick        = pcnt_q == prescale_q;

  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
    if (wr_prescale) begin
      prescale_d = wdata[PRE_W-1:0];
      pcnt_d     = '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             wr_ch;
    logic [3:0]       ctrl, status;
    logic [CNT_W-1:0] open_v, close_v, count;
    logic             irq;
    logic [31:0]      rd_data;

    assign wr_ch = wr_en && (ch_sel == 3'(c));

    tqvp_wdm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (tick),
      .wr_ctrl_i   (wr_ch && (off_sel == OFF_CTRL)),
      .wr_open_i   (wr_ch && (off_sel == OFF_OPEN)),
      .wr_close_i  (wr_ch && (off_sel == OFF_CLOSE)),
      .wr_pat_i    (wr_ch && (off_sel == OFF_PAT)),
      .wr_status_i (wr_ch && (off_sel == OFF_STATUS)),
      .key_ok_i    (key_ok),
      .wdata_i     (wdata[CNT_W-1:0]),
      .ctrl_o      (ctrl),
      .open_o      (open_v),
      .close_o     (close_v),
      .status_o    (status),
      .count_o     (count),
      .irq_o       (irq)
    );

    always_comb begin
      case (off_sel)
        OFF_CTRL:   rd_data = 32'(ctrl);
        OFF_OPEN:   rd_data = 32'(open_v);
        OFF_CLOSE:  rd_data = 32'(close_v);
        OFF_STATUS: rd_data = 32'(status);
        OFF_COUNT:  rd_data = 32'(count);
        default:    rd_data = '0;
      endcase
    end

    assign rd_all[c]  = rd_data;
    assign exp_vec[c] = status[ST_EXPIRED];
    assign irq_vec[c] = irq;
  end

  for (genvar c = NUM_CH; c < 8; c++) begin : g_rd_pad
    assign rd_all[c] = '0;
  end

  for (genvar c = NUM_CH; c < 4; c++) begin : g_vec_pad
    assign exp_vec[c] = 1'b0;
    assign irq_vec[c] = 1'b0;
  end

  always_comb begin
    case (address)
      ADDR_PRESCALE: data_out = 32'(prescale_q);
      ADDR_IRQ:      data_out = 32'(irq_vec);
      ADDR_UI:       data_out = {24'h0, ui_in};
      default:       data_out = rd_all[ch_sel];
    endcase
  end

  assign irq_d = |irq_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
    end
  end

  assign user_interrupt = irq_q;
  assign uo_out         = {irq_q, ~irq_q, 2'b00, exp_vec};
  assign data_ready     = 1'b1;
  assign unused_ok      = &{1'b0, data_read_n, wdata};

endmodule
